// File: rtl/fog_err_demod_mc_pkg.sv
// Shared types and helpers for the FOG multi-channel demodulator.
package fog_err_demod_mc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam int MAX_CH = 8;
    localparam int SAT_W  = 64;

    // Clamp a wide signed value into the signed range of w bits (w < 64).
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] mx;
        logic signed [SAT_W-1:0] mn;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

endpackage

// File: rtl/fog_err_demod_mc_half_acc.sv
// Per-channel accumulator, half-average register and
// diff/offset/saturate stage of the FOG demodulator.
module fog_err_demod_mc_half_acc
    import fog_err_demod_mc_pkg::*;
#(
    parameter int ADC_BIT      = 14,
    parameter int OUT_W        = 32,
    parameter int MAX_AVG_LOG2 = 8,
    parameter int AVG_W        = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               acc_en_i,
    input  logic               acc_clr_i,
    input  logic               latch_hi_i,
    input  logic               latch_lo_i,
    input  logic               pair_i,
    input  logic               upd_i,
    input  logic               pol_i,
    input  logic [AVG_W-1:0]   avg_sel_i,
    input  logic [ADC_BIT-1:0] adc_i,
    input  logic [OUT_W-1:0]   offset_i,
    output logic [OUT_W-1:0]   err_o,
    output logic               sat_o
);

    localparam int ACC_W = ADC_BIT + MAX_AVG_LOG2;
    localparam int DW    = ADC_BIT + 2;

    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ADC_BIT-1:0] hi_q;
    logic        [OUT_W-1:0]   res_q;
    logic        [OUT_W-1:0]   err_q;
    logic                      sat_q;

    logic signed [ACC_W-1:0]   smp_w;
    logic signed [ACC_W-1:0]   sum_w;
    logic signed [ADC_BIT-1:0] avg_w;
    logic signed [DW-1:0]      diff_w;
    logic signed [DW-1:0]      dpol_w;
    logic signed [SAT_W-1:0]   d64_w;
    logic signed [SAT_W-1:0]   o64_w;
    logic signed [SAT_W-1:0]   s64_w;
    logic signed [SAT_W-1:0]   sat_w;
    logic                      ovf_w;

    // The average includes the sample arriving on the latch clock.
    always_comb begin
        smp_w  = {{MAX_AVG_LOG2{adc_i[ADC_BIT-1]}}, adc_i};
        sum_w  = acc_q + smp_w;
        avg_w  = ADC_BIT'(sum_w >>> avg_sel_i);
        diff_w = {{2{hi_q[ADC_BIT-1]}}, hi_q}
               - {{2{avg_w[ADC_BIT-1]}}, avg_w};
        dpol_w = pol_i ? -diff_w : diff_w;
        d64_w  = {{(SAT_W-DW){dpol_w[DW-1]}}, dpol_w};
        o64_w  = {{(SAT_W-OUT_W){offset_i[OUT_W-1]}}, offset_i};
        s64_w  = d64_w + o64_w;
        sat_w  = sat_signed(s64_w, OUT_W);
        ovf_w  = (sat_w != s64_w);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            hi_q  <= '0;
            res_q <= '0;
            err_q <= '0;
            sat_q <= 1'b0;
        end else begin
            if (acc_clr_i) begin
                acc_q <= '0;
            end else if (acc_en_i) begin
                acc_q <= sum_w;
            end
            if (latch_hi_i) begin
                hi_q <= avg_w;
            end
            if (latch_lo_i && pair_i) begin
                res_q <= OUT_W'(sat_w);
                if (ovf_w) begin
                    sat_q <= 1'b1;
                end
            end
            if (upd_i) begin
                err_q <= res_q;
            end
        end
    end

    assign err_o = err_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/fog_err_demod_mc.sv
// Multi-channel square-wave demodulator for the FOG closed loop:
// shared half-period FSM driving one accumulator slice per axis.
module fog_err_demod_mc
    import fog_err_demod_mc_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int ADC_BIT      = 14,
    parameter int OUT_W        = 32,
    parameter int MAX_AVG_LOG2 = 8,
    parameter int DLY_CYC      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_status,
    input  logic                    i_trig,
    input  logic                    i_polarity,
    input  logic [31:0]             i_wait_cnt,
    input  logic [31:0]             i_avg_sel,
    input  logic [N_CH*OUT_W-1:0]   i_err_offset,
    input  logic [N_CH*ADC_BIT-1:0] i_adc_data,
    output logic [N_CH*OUT_W-1:0]   o_err,
    output logic                    o_err_valid,
    output logic                    o_step_sync,
    output logic                    o_step_sync_dly,
    output logic [15:0]             o_miss_cnt,
    output logic [N_CH-1:0]         o_sat
);

    localparam int AVG_W = $clog2(MAX_AVG_LOG2 + 1);
    localparam int SMP_W = MAX_AVG_LOG2 + 1;

    state_t             state_q, state_d;
    logic [31:0]        wcnt_q, wcnt_d;
    logic [SMP_W-1:0]   scnt_q, scnt_d;
    logic [31:0]        wait_q;
    logic [AVG_W-1:0]   avg_q;
    logic               pol_q;
    logic               hi_half_q;
    logic               pair_q, pair_d;
    logic               cmp_q;
    logic               step_q;
    logic               valid_q;
    logic [15:0]        miss_q;
    logic [DLY_CYC-1:0] dly_q;

    logic [AVG_W-1:0]   avg_cl;
    logic [SMP_W-1:0]   lim;
    logic               in_acc;
    logic               last;
    logic               abort;
    logic               lat_hi;
    logic               lat_lo;

    always_comb begin
        avg_cl = (i_avg_sel > 32'(MAX_AVG_LOG2))
               ? AVG_W'(MAX_AVG_LOG2) : i_avg_sel[AVG_W-1:0];
        lim    = (SMP_W'(1) << avg_q) - SMP_W'(1);
        in_acc = (state_q == ACC);
        last   = in_acc && (scnt_q == lim);
        // A trig on the final sample completes the half instead of aborting.
        abort  = i_trig && ((state_q == WAIT) || (in_acc && !last));
        lat_hi = last && hi_half_q;
        lat_lo = last && !hi_half_q;
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        scnt_d  = scnt_q;
        pair_d  = pair_q;
        unique case (state_q)
            IDLE: ;
            WAIT: begin
                if (wcnt_q == wait_q) begin
                    state_d = ACC;
                    scnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                end
            end
            ACC: begin
                if (last) state_d = HOLD;
                else      scnt_d  = scnt_q + SMP_W'(1);
            end
            HOLD: ;
            default: state_d = IDLE;
        endcase
        if (i_trig) begin
            state_d = WAIT;
            wcnt_d  = '0;
        end
        if (lat_hi)         pair_d = 1'b1;
        if (lat_lo || abort) pair_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            scnt_q    <= '0;
            wait_q    <= '0;
            avg_q     <= '0;
            pol_q     <= 1'b0;
            hi_half_q <= 1'b0;
            pair_q    <= 1'b0;
            cmp_q     <= 1'b0;
            step_q    <= 1'b0;
            valid_q   <= 1'b0;
            miss_q    <= '0;
            dly_q     <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            scnt_q  <= scnt_d;
            pair_q  <= pair_d;
            if (i_trig) begin
                wait_q    <= i_wait_cnt;
                avg_q     <= avg_cl;
                pol_q     <= i_polarity;
                hi_half_q <= i_status;
            end
            if (abort && (miss_q != 16'hFFFF)) begin
                miss_q <= miss_q + 16'd1;
            end
            cmp_q  <= lat_lo && pair_q;
            step_q <= cmp_q;
            if (cmp_q) begin
                valid_q <= 1'b1;
            end
            dly_q <= DLY_CYC'({dly_q, step_q});
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        fog_err_demod_mc_half_acc #(
            .ADC_BIT      (ADC_BIT),
            .OUT_W        (OUT_W),
            .MAX_AVG_LOG2 (MAX_AVG_LOG2),
            .AVG_W        (AVG_W)
        ) u_acc (
            .clk_i      (i_clk),
            .rst_i      (i_rst),
            .acc_en_i   (in_acc),
            .acc_clr_i  (!in_acc),
            .latch_hi_i (lat_hi),
            .latch_lo_i (lat_lo),
            .pair_i     (pair_q),
            .upd_i      (cmp_q),
            .pol_i      (pol_q),
            .avg_sel_i  (avg_q),
            .adc_i      (i_adc_data[k*ADC_BIT +: ADC_BIT]),
            .offset_i   (i_err_offset[k*OUT_W +: OUT_W]),
            .err_o      (o_err[k*OUT_W +: OUT_W]),
            .sat_o      (o_sat[k])
        );
    end

    assign o_err_valid     = valid_q;
    assign o_step_sync     = step_q;
    assign o_step_sync_dly = dly_q[DLY_CYC-1];
    assign o_miss_cnt      = miss_q;

endmodule
